// File: rtl/rover_nav_pkg.sv
// Shared types for the rover navigation engine: FSM state encoding and the
// rule that fills the transition table at reset.
package rover_nav_pkg;

    typedef enum logic [1:0] {
        Idle   = 2'd0,
        Move   = 2'd1,
        Arrive = 2'd2
    } nav_state_t;

    // Branch 0 means "stay"; branch c>0 steps c rooms forward around the ring.
    function automatic int unsigned default_next(input int unsigned room,
                                                 input int unsigned cmd,
                                                 input int unsigned num_rooms);
        return (cmd == 0) ? room : (room + cmd) % num_rooms;
    endfunction

endpackage

// File: rtl/rover_nav_table.sv
// Programmable (room, command) -> next-room table: combinational read port,
// range-checked write port with a one-cycle rejection pulse.
module rover_nav_table
    import rover_nav_pkg::*;
#(
    parameter int unsigned NUM_ROOMS = 8,
    parameter int unsigned CMD_W     = 1,
    localparam int unsigned ROOM_W   = $clog2(NUM_ROOMS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROOM_W-1:0] rd_room,
    input  logic [CMD_W-1:0]  rd_cmd,
    output logic [ROOM_W-1:0] rd_next,
    input  logic              we,
    input  logic [ROOM_W-1:0] wr_room,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [ROOM_W-1:0] wr_next,
    output logic              wr_err
);

    localparam int unsigned     NUM_CMDS   = 2 ** CMD_W;
    localparam logic [ROOM_W:0] ROOM_LIMIT = NUM_ROOMS[ROOM_W:0];

    logic [ROOM_W-1:0] tbl_q [NUM_ROOMS][NUM_CMDS];
    logic              wr_ok;

    assign wr_ok   = ({1'b0, wr_room} < ROOM_LIMIT) && ({1'b0, wr_next} < ROOM_LIMIT);
    // Unused encodings (non power-of-two room count) read back as room 0.
    assign rd_next = ({1'b0, rd_room} < ROOM_LIMIT) ? tbl_q[rd_room][rd_cmd] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_ROOMS; r++) begin
                for (int unsigned c = 0; c < NUM_CMDS; c++) begin
                    tbl_q[r][c] <= ROOM_W'(default_next(r, c, NUM_ROOMS));
                end
            end
            wr_err <= 1'b0;
        end else begin
            wr_err <= we && !wr_ok;
            if (we && wr_ok) begin
                tbl_q[wr_room][wr_cmd] <= wr_next;
            end
        end
    end

endmodule

// File: rtl/rover_nav_engine.sv
// Table-driven rover navigation FSM (IDLE/MOVE/ARRIVE) with timed, abortable moves.
// Optional hop odometer is built only when ROVER_ODOMETER_EN is defined.
module rover_nav_engine
    import rover_nav_pkg::*;
#(
    parameter int unsigned NUM_ROOMS   = 8,
    parameter int unsigned CMD_W       = 1,
    parameter int unsigned MOVE_CYCLES = 4,
    parameter int unsigned ODO_W       = 16,
    localparam int unsigned ROOM_W     = $clog2(NUM_ROOMS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd,
    input  logic              abort,
    input  logic              cfg_we,
    input  logic [ROOM_W-1:0] cfg_room,
    input  logic [CMD_W-1:0]  cfg_cmd,
    input  logic [ROOM_W-1:0] cfg_next,
    output logic              cfg_err,
    output logic [ROOM_W-1:0] cur_room,
    output logic [ROOM_W-1:0] tgt_room,
    output logic              moving,
    output logic              arrived,
    output logic              aborted,
    output logic [ODO_W-1:0]  hop_count
);

    localparam int unsigned CNT_W = $clog2(MOVE_CYCLES + 1);

    nav_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROOM_W-1:0] cur_q, cur_d, tgt_q, tgt_d;
    logic [ROOM_W-1:0] tbl_next;
    logic              aborted_q, aborted_d;

    rover_nav_table #(
        .NUM_ROOMS (NUM_ROOMS),
        .CMD_W     (CMD_W)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .rd_room (cur_q),
        .rd_cmd  (cmd),
        .rd_next (tbl_next),
        .we      (cfg_we),
        .wr_room (cfg_room),
        .wr_cmd  (cfg_cmd),
        .wr_next (cfg_next),
        .wr_err  (cfg_err)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        aborted_d = 1'b0;
        case (state_q)
            Idle: begin
                if (cmd_valid) begin
                    tgt_d = tbl_next;
                    if (tbl_next == cur_q) begin
                        state_d = Arrive;
                    end else begin
                        state_d = Move;
                        cnt_d   = CNT_W'(MOVE_CYCLES - 1);
                    end
                end
            end
            Move: begin
                // Abort takes priority over a counter that expires in the same cycle.
                if (abort) begin
                    state_d   = Idle;
                    aborted_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = Arrive;
                    cur_d   = tgt_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            Arrive: state_d = Idle;
            default: begin
                state_d = Idle;
                cur_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= Idle;
            cnt_q     <= '0;
            cur_q     <= '0;
            tgt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            aborted_q <= aborted_d;
        end
    end

    assign cmd_ready = (state_q == Idle);
    assign moving    = (state_q == Move);
    assign arrived   = (state_q == Arrive);
    assign aborted   = aborted_q;
    assign cur_room  = cur_q;
    assign tgt_room  = tgt_q;

`ifdef ROVER_ODOMETER_EN
    logic [ODO_W-1:0] hop_q;
    logic             hop_inc;

    // Every completed MOVE changes rooms; stays never enter MOVE.
    assign hop_inc = (state_q == Move) && !abort && (cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hop_q <= '0;
        end else if (hop_inc && (hop_q != '1)) begin
            hop_q <= hop_q + ODO_W'(1);
        end
    end

    assign hop_count = hop_q;
`else
    assign hop_count = '0;
`endif

endmodule

// File: tb/tb_rover_nav_engine.sv
// Self-checking bench for rover_nav_engine: directed scenarios plus randomized
// moves against a table-level reference model; a second small instance covers write rejection.
module tb_rover_nav_engine;

    localparam int MC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd, abort, cfg_we, cfg_cmd;
    logic [2:0]  cfg_room, cfg_next;
    logic        cmd_ready, cfg_err, moving, arrived, aborted;
    logic [2:0]  cur_room, tgt_room;
    logic [15:0] hop_count;

    logic        b_cmd_valid, b_cmd, b_abort, b_cfg_we, b_cfg_cmd;
    logic [2:0]  b_cfg_room, b_cfg_next;
    logic        b_cmd_ready, b_cfg_err, b_moving, b_arrived, b_aborted;
    logic [2:0]  b_cur_room, b_tgt_room;
    logic [15:0] b_hop_count;

    int n_assert = 0;
    int n_fail   = 0;
    int mtbl [8][2];
    int mcur, mhop, b_hops;

    always #5 clk = ~clk;

    rover_nav_engine #(.NUM_ROOMS(8), .CMD_W(1), .MOVE_CYCLES(MC), .ODO_W(16)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .abort(abort), .cfg_we(cfg_we), .cfg_room(cfg_room), .cfg_cmd(cfg_cmd),
        .cfg_next(cfg_next), .cfg_err(cfg_err), .cur_room(cur_room), .tgt_room(tgt_room),
        .moving(moving), .arrived(arrived), .aborted(aborted), .hop_count(hop_count)
    );

    rover_nav_engine #(.NUM_ROOMS(6), .CMD_W(1), .MOVE_CYCLES(2), .ODO_W(16)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd(b_cmd), .abort(b_abort), .cfg_we(b_cfg_we), .cfg_room(b_cfg_room),
        .cfg_cmd(b_cfg_cmd), .cfg_next(b_cfg_next), .cfg_err(b_cfg_err),
        .cur_room(b_cur_room), .tgt_room(b_tgt_room), .moving(b_moving),
        .arrived(b_arrived), .aborted(b_aborted), .hop_count(b_hop_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 2; c++) mtbl[r][c] = (c == 0) ? r : (r + c) % 8;
        end
        mcur = 0;
        mhop = 0;
    endtask

    task automatic model_hop();
`ifdef ROVER_ODOMETER_EN
        if (mhop < 65535) mhop++;
`endif
    endtask

    task automatic drive_cfg(input int r, input int c, input int n);
        cfg_we   = 1'b1;
        cfg_room = 3'(r);
        cfg_cmd  = 1'(c);
        cfg_next = 3'(n);
    endtask

    task automatic cfg_write(input int r, input int c, input int n);
        drive_cfg(r, c, n);
        step();
        cfg_we = 1'b0;
        mtbl[r][c] = n;
        chk("cfg_write_no_err", cfg_err, 0);
    endtask

    // One full transaction from IDLE; abort_at selects the MOVE cycle to abort on (-1: none).
    task automatic do_move(input int c, input int abort_at, input bit wr_same, input bit wr_mid);
        int src, tgt, n_same, n_mid;
        src    = mcur;
        tgt    = mtbl[src][c];
        n_same = $urandom_range(0, 7);
        n_mid  = $urandom_range(0, 7);
        chk("ready_before", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd       = 1'(c);
        if (wr_same) drive_cfg(src, c, n_same);
        step();
        cmd_valid = 1'b0;
        cfg_we    = 1'b0;
        if (wr_same) mtbl[src][c] = n_same;
        chk("tgt_latched", tgt_room, tgt);
        chk("cfg_err_clear", cfg_err, 0);
        if (tgt == src) begin
            chk("stay_arrived", arrived, 1);
            chk("stay_moving", moving, 0);
            chk("stay_room", cur_room, src);
            chk("stay_hops", hop_count, mhop);
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("stay_abort_ignored", aborted, 0);
            chk("stay_arrive_end", arrived, 0);
            chk("stay_ready", cmd_ready, 1);
            return;
        end
        for (int k = 0; k < MC; k++) begin
            chk("move_moving", moving, 1);
            chk("move_room", cur_room, src);
            chk("move_busy", cmd_ready, 0);
            if (wr_mid && k == 0) drive_cfg(src, c, n_mid);
            if (k == abort_at) abort = 1'b1;
            step();
            if (wr_mid && k == 0) begin
                cfg_we = 1'b0;
                mtbl[src][c] = n_mid;
            end
            if (k == abort_at) begin
                abort = 1'b0;
                chk("abort_pulse", aborted, 1);
                chk("abort_room", cur_room, src);
                chk("abort_ready", cmd_ready, 1);
                chk("abort_no_arrive", arrived, 0);
                step();
                chk("abort_pulse_end", aborted, 0);
                return;
            end
        end
        chk("arrive_pulse", arrived, 1);
        chk("arrive_moving", moving, 0);
        chk("arrive_room", cur_room, tgt);
        mcur = tgt;
        model_hop();
        chk("hops", hop_count, mhop);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("arrive_end", arrived, 0);
        chk("arrive_abort_ignored", aborted, 0);
        chk("ready_after", cmd_ready, 1);
    endtask

    initial begin
        reset = 1'b1;
        {cmd_valid, cmd, abort, cfg_we, cfg_cmd, cfg_room, cfg_next} = '0;
        {b_cmd_valid, b_cmd, b_abort, b_cfg_we, b_cfg_cmd, b_cfg_room, b_cfg_next} = '0;
        b_hops = 0;
        model_reset();
        #3;
        chk("rst_cur", cur_room, 0);
        chk("rst_tgt", tgt_room, 0);
        chk("rst_moving", moving, 0);
        chk("rst_arrived", arrived, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_hops", hop_count, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        do_move(1, -1, 1'b0, 1'b0);        // 0 -> 1, full latency
        do_move(1, -1, 1'b0, 1'b0);        // 1 -> 2
        do_move(1, 1, 1'b0, 1'b0);         // abort on 2nd MOVE cycle
        do_move(1, MC - 1, 1'b0, 1'b0);    // abort on final MOVE cycle
        do_move(1, -1, 1'b0, 1'b0);        // 2 -> 3
        do_move(0, -1, 1'b0, 1'b0);        // stay in 3
        cfg_write(3, 1, 0);
        do_move(1, -1, 1'b0, 1'b0);        // 3 -> 0 via written entry
        cfg_write(0, 1, 7);
        do_move(1, -1, 1'b0, 1'b0);        // 0 -> 7
        chk("room_after_write", cur_room, 7);

        // Reset in the middle of a move.
        cmd_valid = 1'b1;
        cmd       = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("pre_reset_moving", moving, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_moving", moving, 0);
        chk("mid_rst_cur", cur_room, 0);
        chk("mid_rst_tgt", tgt_room, 0);
        chk("mid_rst_arrived", arrived, 0);
        chk("mid_rst_aborted", aborted, 0);
        chk("mid_rst_hops", hop_count, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step();
        do_move(1, -1, 1'b0, 1'b0);        // default T[0][1]=1 restored
        chk("default_restored", cur_room, 1);

        for (int i = 0; i < 40; i++) begin
            int ab;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MC - 1)) : -1;
            if ($urandom_range(0, 3) == 0) begin
                cfg_write($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7));
            end
            do_move($urandom_range(0, 1), ab, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        // Write rejection on a 6-room instance: rows/values 6 and 7 are out of range.
        b_cfg_we = 1'b1; b_cfg_room = 3'd0; b_cfg_cmd = 1'b1; b_cfg_next = 3'd6;
        step();
        b_cfg_we = 1'b0;
        chk("b_err_next", b_cfg_err, 1);
        b_cfg_we = 1'b1; b_cfg_room = 3'd7; b_cfg_next = 3'd2;
        step();
        b_cfg_we = 1'b0;
        chk("b_err_room", b_cfg_err, 1);
        step();
        chk("b_err_pulse_end", b_cfg_err, 0);
        chk("b_ready", b_cmd_ready, 1);
        b_cmd_valid = 1'b1; b_cmd = 1'b1;
        step();
        b_cmd_valid = 1'b0;
        chk("b_tgt_unchanged", b_tgt_room, 1);
        chk("b_moving", b_moving, 1);
        step();
        step();
        chk("b_arrived", b_arrived, 1);
        chk("b_cur", b_cur_room, 1);
`ifdef ROVER_ODOMETER_EN
        b_hops++;
`endif
        b_cfg_we = 1'b1; b_cfg_room = 3'd1; b_cfg_cmd = 1'b1; b_cfg_next = 3'd5;
        step();
        b_cfg_we = 1'b0;
        chk("b_valid_no_err", b_cfg_err, 0);
        b_cmd_valid = 1'b1;
        step();
        b_cmd_valid = 1'b0;
        chk("b_tgt_written", b_tgt_room, 5);
        step();
        step();
        chk("b_cur_written", b_cur_room, 5);
        chk("b_aborted", b_aborted, 0);
`ifdef ROVER_ODOMETER_EN
        b_hops++;
`endif
        chk("b_hops", b_hop_count, b_hops);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
